// File: rtl/imem_loader.sv
// imem_loader: streams a program into a 256x8 instruction RAM,
// then releases the core from reset and serves fetches from pc.
module imem_loader #(
  parameter int ADDR_W = 8,
  parameter int DATA_W = 8,
  parameter int DEPTH  = 256
) (
  input  logic              clk,
  input  logic              CLB,
  input  logic              load_start,
  input  logic [DATA_W-1:0] rx_data,
  input  logic              rx_valid,
  output logic              rx_ready,
  input  logic [ADDR_W-1:0] pc,
  output logic [DATA_W-1:0] input_ins,
  output logic              core_clb,
  output logic              running,
  output logic [ADDR_W:0]   load_count
);

  localparam int CW = ADDR_W + 1;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_LEN  = 2'd1;
  localparam logic [1:0] S_DATA = 2'd2;
  localparam logic [1:0] S_RUN  = 2'd3;

  logic [1:0]        r_state;
  logic [ADDR_W-1:0] r_addr_q;
  logic [CW-1:0]     r_len;
  logic [CW-1:0]     r_load_count;
  logic              r_core_clb;
  logic              r_running;
  logic [DATA_W-1:0] r_mem [DEPTH];

  logic              w_xfer;
  logic              w_wr;
  logic [CW-1:0]     w_cnt_nxt;

  assign rx_ready  = (r_state == S_LEN) || (r_state == S_DATA);
  assign w_xfer    = rx_valid && rx_ready;
  // load_start beats a same-cycle transfer; that byte is dropped
  assign w_wr      = w_xfer && !load_start && (r_state == S_DATA);
  assign w_cnt_nxt = r_load_count + CW'(1);

  always_ff @(posedge clk or negedge CLB) begin
    if (!CLB) begin
      r_state      <= S_IDLE;
      r_addr_q     <= '0;
      r_len        <= '0;
      r_load_count <= '0;
      r_core_clb   <= 1'b0;
      r_running    <= 1'b0;
    end else if (load_start) begin
      r_state    <= S_LEN;
      r_addr_q   <= '0;
      r_core_clb <= 1'b0;
      r_running  <= 1'b0;
    end else begin
      unique case (1'b1)
        (r_state == S_LEN): begin
          if (w_xfer) begin
            // a zero length byte encodes a full-depth program
            r_len        <= (rx_data == '0) ? CW'(DEPTH)
                                            : CW'(rx_data);
            r_load_count <= '0;
            r_state      <= S_DATA;
          end
        end
        (r_state == S_DATA): begin
          if (w_xfer) begin
            r_load_count <= w_cnt_nxt;
            if (w_cnt_nxt == r_len) begin
              r_state    <= S_RUN;
              r_core_clb <= 1'b1;
              r_running  <= 1'b1;
            end
          end
        end
        (r_state == S_RUN): begin
          r_addr_q <= pc;
        end
        default: begin
        end
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_load_count[ADDR_W-1:0]] <= rx_data;
    end
  end

  assign input_ins  = (r_state == S_RUN) ? r_mem[r_addr_q] : '0;
  assign core_clb   = r_core_clb;
  assign running    = r_running;
  assign load_count = r_load_count;

endmodule

// File: tb/tb_imem_loader.sv
// tb_imem_loader: directed checks of load, fetch, reload and
// reset behaviour of imem_loader.
module tb_imem_loader;

  logic       clk;
  logic       CLB;
  logic       load_start;
  logic [7:0] rx_data;
  logic       rx_valid;
  logic       rx_ready;
  logic [7:0] pc;
  logic [7:0] input_ins;
  logic       core_clb;
  logic       running;
  logic [8:0] load_count;

  int n_total = 0;
  int n_fail  = 0;

  imem_loader dut (
    .clk        (clk),
    .CLB        (CLB),
    .load_start (load_start),
    .rx_data    (rx_data),
    .rx_valid   (rx_valid),
    .rx_ready   (rx_ready),
    .pc         (pc),
    .input_ins  (input_ins),
    .core_clb   (core_clb),
    .running    (running),
    .load_count (load_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag,
                     input logic [31:0] obs,
                     input logic [31:0] exp);
    n_total++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic send(input logic [7:0] b);
    rx_valid = 1'b1;
    rx_data  = b;
    tick();
    rx_valid = 1'b0;
  endtask

  task automatic start();
    load_start = 1'b1;
    tick();
    load_start = 1'b0;
  endtask

  initial begin
    CLB        = 1'b0;
    load_start = 1'b0;
    rx_data    = '0;
    rx_valid   = 1'b0;
    pc         = '0;
    tick();
    tick();
    chk("rst_ready", rx_ready, 0);
    chk("rst_ins", input_ins, 0);
    chk("rst_clb", core_clb, 0);
    chk("rst_run", running, 0);
    chk("rst_cnt", load_count, 0);
    CLB = 1'b1;
    tick();
    chk("idle_ready", rx_ready, 0);

    // test 1
    start();
    chk("t1_len_ready", rx_ready, 1);
    send(8'h03);
    chk("t1_data_ready", rx_ready, 1);
    send(8'hA1);
    send(8'hB2);
    chk("t1_not_run", running, 0);
    chk("t1_cnt2", load_count, 2);
    send(8'hC3);
    chk("t1_run", running, 1);
    chk("t1_clb", core_clb, 1);
    chk("t1_cnt", load_count, 3);
    chk("t1_ready0", rx_ready, 0);

    // test 2
    pc = 8'd0; tick();
    chk("t2_pc0", input_ins, 8'hA1);
    pc = 8'd1; tick();
    chk("t2_pc1", input_ins, 8'hB2);
    pc = 8'd2; tick();
    chk("t2_pc2", input_ins, 8'hC3);

    // test 4: toggled valid, stale data on idle cycles
    pc = 8'd0;
    start();
    chk("t4_clb0", core_clb, 0);
    chk("t4_ins0", input_ins, 0);
    send(8'h03);
    rx_valid = 1'b1; rx_data = 8'h11; tick();
    rx_valid = 1'b0; rx_data = 8'hFF; tick();
    chk("t4_hold_cnt", load_count, 1);
    rx_valid = 1'b1; rx_data = 8'h22; tick();
    rx_valid = 1'b0; rx_data = 8'hEE; tick();
    rx_valid = 1'b1; rx_data = 8'h33; tick();
    rx_valid = 1'b0;
    chk("t4_run", running, 1);
    chk("t4_cnt", load_count, 3);
    pc = 8'd0; tick();
    chk("t4_pc0", input_ins, 8'h11);
    pc = 8'd1; tick();
    chk("t4_pc1", input_ins, 8'h22);
    pc = 8'd2; tick();
    chk("t4_pc2", input_ins, 8'h33);

    // test 5: reload of 1 byte keeps RAM[1]
    start();
    chk("t5_clb0", core_clb, 0);
    chk("t5_ins0", input_ins, 0);
    chk("t5_run0", running, 0);
    send(8'h01);
    send(8'h7E);
    chk("t5_run", running, 1);
    chk("t5_cnt", load_count, 1);
    pc = 8'd0; tick();
    chk("t5_pc0", input_ins, 8'h7E);
    pc = 8'd1; tick();
    chk("t5_pc1", input_ins, 8'h22);

    // load_start with a same-cycle transfer drops the byte
    start();
    load_start = 1'b1; rx_valid = 1'b1; rx_data = 8'h05;
    tick();
    load_start = 1'b0; rx_valid = 1'b0;
    chk("ls_win_ready", rx_ready, 1);
    chk("ls_win_run", running, 0);

    // test 3: full 256-byte program
    send(8'h00);
    for (int i = 0; i < 255; i++) begin
      send(8'(i) ^ 8'h5A);
    end
    chk("t3_not_run", running, 0);
    chk("t3_cnt255", load_count, 255);
    send(8'hFF ^ 8'h5A);
    chk("t3_run", running, 1);
    chk("t3_cnt", load_count, 256);
    pc = 8'hFF; tick();
    chk("t3_pcFF", input_ins, 8'hA5);
    pc = 8'h00; tick();
    chk("t3_pc00", input_ins, 8'h5A);

    // test 6: async reset mid-load
    start();
    send(8'h03);
    send(8'hD1);
    send(8'hD2);
    CLB = 1'b0;
    #1;
    chk("t6_ready", rx_ready, 0);
    chk("t6_clb", core_clb, 0);
    chk("t6_run", running, 0);
    chk("t6_cnt", load_count, 0);
    CLB = 1'b1;
    send(8'h55);
    tick();
    chk("t6_ign_ready", rx_ready, 0);
    chk("t6_ign_cnt", load_count, 0);
    chk("t6_ign_ins", input_ins, 0);
    start();
    chk("t6_restart", rx_ready, 1);

    $display("%0d/%0d checks passed", n_total - n_fail, n_total);
    $finish;
  end

endmodule
